// File: rtl/v_tile_pkg.sv
// Shared types and field positions for the vector tile output router.
package v_tile_pkg;

   // Field layout of the 4-bit destination code from the adder FU.
   localparam int DEST_VALID_BIT = 3;
   localparam int DEST_IDX_LSB   = 0;
   localparam int DEST_IDX_W     = 2;

   // Default result geometry; the router builds its own entry type from its parameters.
   localparam int DEF_WIDTH      = 16;
   localparam int DEF_NUM_INPUTS = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RDY = 2'd1,
      SEND     = 2'd2
   } out_state_t;

   typedef struct packed {
      logic [DEF_NUM_INPUTS-1:0][DEF_WIDTH-1:0] data;
      logic [DEST_IDX_W-1:0]                    dest;
   } out_entry_t;

endpackage

// File: rtl/v_tile_out_router_if.sv
// Network write port shared by the router and its neighbours: one data bus,
// per-neighbour write request, ready and acknowledge.
interface v_tile_out_router_if #(
   parameter int width      = 16,
   parameter int num_inputs = 4,
   parameter int num_dests  = 4
);
   logic [num_inputs-1:0][width-1:0] out_data;
   logic [num_dests-1:0]             out_write_en;
   logic [num_dests-1:0]             out_write_rdy;
   logic [num_dests-1:0]             out_write_ack;

   modport master (
      output out_data,
      output out_write_en,
      input  out_write_rdy,
      input  out_write_ack
   );

   modport slave (
      input  out_data,
      input  out_write_en,
      output out_write_rdy,
      output out_write_ack
   );
endinterface

// File: rtl/v_tile_out_fifo.sv
// Small synchronous FIFO of result entries. A push while full is accepted
// when a pop happens on the same edge. Pointers carry one extra bit so that
// full and empty can be told apart.
module v_tile_out_fifo import v_tile_pkg::*; #(
   parameter type entry_t = out_entry_t,
   parameter int  depth   = 2
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  logic   pop,
   input  entry_t wdata,
   output entry_t head,
   output logic   full,
   output logic   empty
);
   localparam int AW = $clog2(depth);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   entry_t      mem [depth];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage write; entries need no reset because empty gates the head.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Pointer advance, wrapping naturally modulo twice the depth.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Head presentation, forced to zeros while empty.
   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr[AW-1:0]];
   end
endmodule

// File: rtl/v_tile_out_router.sv
// Output router of the vector tile: buffers adder results and delivers each
// one to the neighbour named in its destination code, holding write_en until
// that neighbour acknowledges or the timeout expires.
module v_tile_out_router import v_tile_pkg::*; #(
   parameter int width          = 16,
   parameter int num_inputs     = 4,
   parameter int num_dests      = 4,
   parameter int fifo_depth     = 2,
   parameter int timeout_cycles = 64
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [num_inputs-1:0][width-1:0] adder_outputs,
   input  logic [3:0]                       dest_info,
   input  logic                             adder_ack,
   output logic                             in_rdy,
   v_tile_out_router_if.master              net,
   output logic                             err_overflow,
   output logic                             err_timeout,
   input  logic                             err_clear,
   output logic [15:0]                      sent_count
);
   typedef struct packed {
      logic [num_inputs-1:0][width-1:0] data;
      logic [DEST_IDX_W-1:0]            dest;
   } entry_t;

   localparam int          TMO_W    = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   localparam int unsigned TMO_LAST = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;
   localparam logic [DEST_IDX_W:0] NUM_DESTS_C = (DEST_IDX_W + 1)'(num_dests);

   out_state_t            state;
   logic [num_dests-1:0]  write_en;
   logic [num_dests-1:0]  sel;
   logic [TMO_W-1:0]      tmo_cnt;
   logic [DEST_IDX_W-1:0] dest_idx;
   logic                  dest_ok;
   logic                  push_req;
   logic                  ack_hit;
   logic                  rdy_hit;
   logic                  tmo_fire;
   logic                  pop;
   logic                  overflow_set;
   logic                  full;
   logic                  empty;
   entry_t                head;
   entry_t                wdata;
   logic                  unused_reserved;

   assign unused_reserved = dest_info[2];

   // Incoming result qualification: invalid or out-of-range destinations vanish quietly.
   assign dest_idx     = dest_info[DEST_IDX_LSB +: DEST_IDX_W];
   assign dest_ok      = dest_info[DEST_VALID_BIT] && ({1'b0, dest_idx} < NUM_DESTS_C);
   assign push_req     = adder_ack && dest_ok;
   assign wdata.data   = adder_outputs;
   assign wdata.dest   = dest_idx;

   // Ack only counts from the selected port while sending; an ack beats a coincident timeout.
   assign ack_hit      = (state == SEND) && |(net.out_write_ack & sel);
   assign rdy_hit      = (state == WAIT_RDY) && |(net.out_write_rdy & sel);
   assign tmo_fire     = (timeout_cycles != 0) && (state != IDLE) &&
                         (tmo_cnt == TMO_W'(TMO_LAST)) && !ack_hit;
   assign pop          = ack_hit || tmo_fire;
   assign overflow_set = push_req && full && !pop;

   v_tile_out_fifo #(
      .entry_t (entry_t),
      .depth   (fifo_depth)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .wdata (wdata),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   // One-hot decode of the head entry's destination.
   always_comb begin
      sel = '0;
      for (int i = 0; i < num_dests; i++) begin
         sel[i] = (head.dest == DEST_IDX_W'(i));
      end
   end

   // Delivery FSM with registered write request, timeout counter and delivery count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         write_en   <= '0;
         tmo_cnt    <= '0;
         sent_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (!empty) state <= WAIT_RDY;
            end
            WAIT_RDY: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_fire) begin
                  state <= IDLE;
               end else if (rdy_hit) begin
                  state    <= SEND;
                  write_en <= sel;
               end
            end
            SEND: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (ack_hit) begin
                  state      <= IDLE;
                  write_en   <= '0;
                  sent_count <= sent_count + 16'd1;
               end else if (tmo_fire) begin
                  state    <= IDLE;
                  write_en <= '0;
               end
            end
            default: begin
               state    <= IDLE;
               write_en <= '0;
            end
         endcase
      end
   end

   // Sticky error flags; a set on the same edge as a clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         if (overflow_set)   err_overflow <= 1'b1;
         else if (err_clear) err_overflow <= 1'b0;
         if (tmo_fire)       err_timeout  <= 1'b1;
         else if (err_clear) err_timeout  <= 1'b0;
      end
   end

   assign in_rdy           = !full;
   assign net.out_data     = head.data;
   assign net.out_write_en = write_en;
endmodule

// File: tb/tb_v_tile_out_router.sv
// Randomised and directed bench for v_tile_out_router against a queue-based
// reference model of the delivery rules.
module tb_v_tile_out_router;
   import v_tile_pkg::*;

   localparam int W     = 16;
   localparam int NI    = 4;
   localparam int ND    = 3;
   localparam int DEPTH = 2;
   localparam int TMO   = 8;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [NI-1:0][W-1:0]      adder_outputs = '0;
   logic [3:0]                dest_info = '0;
   logic                      adder_ack = 1'b0;
   logic                      in_rdy;
   logic                      err_overflow;
   logic                      err_timeout;
   logic                      err_clear = 1'b0;
   logic [15:0]               sent_count;

   always #5 clk = ~clk;

   v_tile_out_router_if #(.width(W), .num_inputs(NI), .num_dests(ND)) net ();

   v_tile_out_router #(
      .width          (W),
      .num_inputs     (NI),
      .num_dests      (ND),
      .fifo_depth     (DEPTH),
      .timeout_cycles (TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .adder_outputs (adder_outputs),
      .dest_info     (dest_info),
      .adder_ack     (adder_ack),
      .in_rdy        (in_rdy),
      .net           (net),
      .err_overflow  (err_overflow),
      .err_timeout   (err_timeout),
      .err_clear     (err_clear),
      .sent_count    (sent_count)
   );

   // Reference model: pending results in order, plus delivery progress of the head.
   typedef struct {
      logic [NI-1:0][W-1:0] data;
      int                   dest;
   } ment_t;

   ment_t mq[$];
   bit    m_busy;      // head has been picked up for delivery
   bit    m_granted;   // write request to the head's neighbour is up
   int    m_age;       // cycles since the head was picked up
   int    m_sent;
   bit    m_ovf;
   bit    m_tmo;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_busy    = 0;
      m_granted = 0;
      m_age     = 0;
      m_sent    = 0;
      m_ovf     = 0;
      m_tmo     = 0;
   endfunction

   // Apply one clock edge worth of rules, using the inputs present at the edge.
   function automatic void model_edge();
      int    hd;
      bit    acked, ready, expired, popped, valid, taken;
      ment_t e;
      hd      = (mq.size() > 0) ? mq[0].dest : 0;
      acked   = m_granted && net.out_write_ack[hd];
      ready   = m_busy && !m_granted && net.out_write_rdy[hd];
      expired = (TMO > 0) && m_busy && (m_age == TMO - 1) && !acked;
      popped  = acked || expired;
      valid   = adder_ack && dest_info[3] && (int'(dest_info[1:0]) < ND);
      taken   = valid && ((mq.size() < DEPTH) || popped);

      if (valid && !taken) m_ovf = 1;
      else if (err_clear)  m_ovf = 0;
      if (expired)         m_tmo = 1;
      else if (err_clear)  m_tmo = 0;

      if (m_busy) begin
         m_age++;
         if (popped) begin
            m_busy    = 0;
            m_granted = 0;
            if (acked) m_sent++;
         end else if (ready) begin
            m_granted = 1;
         end
      end else if (mq.size() > 0) begin
         m_busy = 1;
         m_age  = 0;
      end

      if (popped) void'(mq.pop_front());
      if (taken) begin
         e.data = adder_outputs;
         e.dest = int'(dest_info[1:0]);
         mq.push_back(e);
      end
   endfunction

   task automatic check_outputs();
      logic [ND-1:0]        exp_en;
      logic [NI-1:0][W-1:0] exp_data;
      logic [15:0]          exp_sent;
      exp_en   = '0;
      exp_data = '0;
      if (m_granted) exp_en[mq[0].dest] = 1'b1;
      if (mq.size() > 0) exp_data = mq[0].data;
      exp_sent = m_sent[15:0];
      check("in_rdy",       in_rdy,           mq.size() < DEPTH);
      check("write_en",     net.out_write_en, exp_en);
      check("out_data",     net.out_data,     exp_data);
      check("sent_count",   sent_count,       exp_sent);
      check("err_overflow", err_overflow,     m_ovf);
      check("err_timeout",  err_timeout,      m_tmo);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic push_one(input logic [NI-1:0][W-1:0] d, input logic [3:0] di);
      adder_outputs = d;
      dest_info     = di;
      adder_ack     = 1'b1;
      step();
      adder_ack     = 1'b0;
   endtask

   // Step until a write request appears, within a cycle budget.
   task automatic wait_en(input string tag, input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         if (net.out_write_en != '0) begin
            seen = 1;
            break;
         end
         step();
      end
      if (net.out_write_en != '0) seen = 1;
      check(tag, seen, 1'b1);
   endtask

   task automatic ack_current();
      net.out_write_ack = net.out_write_en;
      step();
      net.out_write_ack = '0;
   endtask

   function automatic logic [NI-1:0][W-1:0] lanes(input int a, input int b, input int c, input int d);
      logic [NI-1:0][W-1:0] v;
      v = {W'(a), W'(b), W'(c), W'(d)};
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NI-1:0][W-1:0] da, db, dc;
      net.out_write_rdy = '0;
      net.out_write_ack = '0;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      check("rst_in_rdy", in_rdy, 1'b1);
      @(negedge clk);
      reset = 1'b1;

      // Single delivery to neighbour 1, acknowledged a few cycles into SEND.
      net.out_write_rdy = 3'b010;
      da = lanes(1, 2, 3, 4);
      push_one(da, 4'b1001);
      check("t1_en_E0", net.out_write_en, 3'b000);
      step();
      check("t1_en_E1", net.out_write_en, 3'b000);
      step();
      check("t1_en_E2", net.out_write_en, 3'b010);
      check("t1_data", net.out_data, da);
      step();
      step();
      ack_current();
      check("t1_en_after_ack", net.out_write_en, 3'b000);
      check("t1_sent", sent_count, 16'd1);

      // Three back-to-back results with no neighbour ready: third one overflows.
      net.out_write_rdy = '0;
      da = lanes(16'h11, 16'h12, 16'h13, 16'h14);
      db = lanes(16'h21, 16'h22, 16'h23, 16'h24);
      dc = lanes(16'h31, 16'h32, 16'h33, 16'h34);
      push_one(da, 4'b1000);
      push_one(db, 4'b1010);
      push_one(dc, 4'b1001);
      check("t2_overflow", err_overflow, 1'b1);
      check("t2_full", in_rdy, 1'b0);
      net.out_write_rdy = 3'b111;
      wait_en("t2_wait_a", 10);
      check("t2_first_data", net.out_data, da);
      check("t2_first_en", net.out_write_en, 3'b001);
      ack_current();
      wait_en("t2_wait_b", 10);
      check("t2_second_data", net.out_data, db);
      check("t2_second_en", net.out_write_en, 3'b100);
      ack_current();
      repeat (4) step();
      check("t2_no_third", net.out_write_en, 3'b000);
      check("t2_sent", sent_count, 16'd3);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("t2_clear", err_overflow, 1'b0);

      // Invalid destination codes are dropped silently.
      push_one(lanes(5, 6, 7, 8), 4'b0010);
      push_one(lanes(9, 10, 11, 12), 4'b1011);
      repeat (4) step();
      check("t3_no_en", net.out_write_en, 3'b000);
      check("t3_no_ovf", err_overflow, 1'b0);
      check("t3_sent", sent_count, 16'd3);
      check("t3_empty", net.out_data, '0);

      // Timeout of an unacknowledged head, then the next entry proceeds.
      da = lanes(16'hAA, 16'hAB, 16'hAC, 16'hAD);
      db = lanes(16'hBA, 16'hBB, 16'hBC, 16'hBD);
      push_one(da, 4'b1001);
      push_one(db, 4'b1000);
      wait_en("t4_wait_a", 10);
      for (int i = 0; i < 12 && net.out_write_en != '0; i++) step();
      check("t4_en_dropped", net.out_write_en, 3'b000);
      check("t4_timeout", err_timeout, 1'b1);
      check("t4_sent_same", sent_count, 16'd3);
      wait_en("t4_wait_b", 10);
      check("t4_next_data", net.out_data, db);
      ack_current();
      check("t4_sent", sent_count, 16'd4);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("t4_clear", err_timeout, 1'b0);

      // Asynchronous reset while a write request is up.
      push_one(lanes(3, 3, 3, 3), 4'b1010);
      wait_en("t5_wait", 10);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("t5_en_async", net.out_write_en, 3'b000);
      check("t5_sent_async", sent_count, 16'd0);
      check("t5_in_rdy", in_rdy, 1'b1);
      check("t5_data", net.out_data, '0);
      @(negedge clk);
      reset = 1'b1;
      net.out_write_ack = 3'b111;
      step();
      net.out_write_ack = '0;
      repeat (2) step();
      check("t5_late_ack", sent_count, 16'd0);
      check("t5_idle", net.out_write_en, 3'b000);

      // Readiness dropping during SEND and an ack on the wrong port are ignored.
      da = lanes(16'h55, 16'h66, 16'h77, 16'h88);
      net.out_write_rdy = 3'b100;
      push_one(da, 4'b1010);
      wait_en("t6_wait", 10);
      net.out_write_rdy = '0;
      step();
      check("t6_hold_en", net.out_write_en, 3'b100);
      net.out_write_ack = 3'b011;
      step();
      net.out_write_ack = '0;
      check("t6_wrong_ack", net.out_write_en, 3'b100);
      check("t6_hold_data", net.out_data, da);
      ack_current();
      check("t6_done", sent_count, 16'd1);

      // Randomised traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         adder_ack         = ($urandom_range(0, 2) == 0);
         dest_info         = 4'($urandom);
         adder_outputs     = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
         net.out_write_rdy = ND'($urandom);
         net.out_write_ack = ($urandom_range(0, 1) == 1) ? ND'($urandom) : '0;
         err_clear         = ($urandom_range(0, 15) == 0);
         step();
      end
      adder_ack         = 1'b0;
      net.out_write_rdy = '0;
      net.out_write_ack = '0;
      err_clear         = 1'b0;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
